// File: rtl/dmem_pkg.sv
// Shared types, default widths and the access-error rule for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_DATA_W      = 32;
  localparam int unsigned DEF_DEPTH       = 128;
  localparam int unsigned DEF_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmemState_e;

  // Misaligned or beyond the stored word range.
  function automatic logic accessErr(input logic [63:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || (addr >= (64'(depth) * 64'd4));
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between a CPU-side master and the memory responder.
interface dmem_responder_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [DATA_W-1:0] resp_rdata_o;
  logic              resp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

endinterface

// File: rtl/dmem_wait_ctr.sv
// Loadable down-counter that models access latency; done_c is high while the count is zero.
module dmem_wait_ctr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             done_c
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU load/store port: one request at a time, fixed latency.
// Optional access-error checking is enabled with `define DMEM_ERR_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  dmemState_e        state;
  logic              reqReady;
  logic              respValid;
  logic [DATA_W-1:0] respRdata;
  logic              respErr;
  logic              weQ;
  logic [IDX_W-1:0]  idxQ;
  logic [DATA_W-1:0] wdataQ;
  logic              errQ;
  logic              accept_c;
  logic              cntDone_c;
  logic              memWe_c;
  logic [CNT_W-1:0]  cntVal;

  logic [DATA_W-1:0] mem [DEPTH];

  assign accept_c = (state == IDLE) && bus.req_valid_i && reqReady;
  assign memWe_c  = (state == WAIT) && cntDone_c && weQ && !errQ;

  dmem_wait_ctr #(.WIDTH(CNT_W)) uWaitCtr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (accept_c),
    .loadVal (CNT_W'(WAIT_CYCLES)),
    .dec     (state == WAIT),
    .count   (cntVal),
    .done_c  (cntDone_c)
  );

`ifdef DMEM_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      errQ <= 1'b0;
    end else if (accept_c) begin
      errQ <= accessErr(64'(bus.req_addr_i), DEPTH);
    end
  end
`else
  assign errQ = 1'b0;
`endif

  // The request always spends WAIT_CYCLES+1 cycles in WAIT so the access uses latched fields.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      reqReady  <= 1'b1;
      respValid <= 1'b0;
      respRdata <= '0;
      respErr   <= 1'b0;
      weQ       <= 1'b0;
      idxQ      <= '0;
      wdataQ    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            weQ      <= bus.req_we_i;
            idxQ     <= bus.req_addr_i[2 +: IDX_W];
            wdataQ   <= bus.req_wdata_i;
            reqReady <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cntDone_c) begin
            respRdata <= (weQ || errQ) ? '0 : mem[idxQ];
            respErr   <= errQ;
            respValid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready_i) begin
            respValid <= 1'b0;
            reqReady  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          respValid <= 1'b0;
          reqReady  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; a store commits on the edge that enters RESP.
  always_ff @(posedge clk_i) begin
    if (memWe_c) begin
      mem[idxQ] <= wdataQ;
    end
  end

  assign bus.req_ready_o  = reqReady;
  assign bus.resp_valid_o = respValid;
  assign bus.resp_rdata_o = respRdata;
  assign bus.resp_err_o   = respErr;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (WAIT_CYCLES=2 and 0) against an array-based memory model.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic clk;
  logic rst;

  logic          reqValid  [2];
  logic          reqWe     [2];
  logic [AW-1:0] reqAddr   [2];
  logic [DW-1:0] reqWdata  [2];
  logic          respReady [2];
  logic          reqReady  [2];
  logic          respValid [2];
  logic [DW-1:0] respRdata [2];
  logic          respErr   [2];

  logic [DW-1:0] modelMem [2][DEPTH];
  bit            known    [2][DEPTH];

  int   errors = 0;
  int   checks = 0;
  time  acceptTime [2];

  dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) ifA ();
  dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) ifB ();

  assign ifA.req_valid_i  = reqValid[0];
  assign ifA.req_we_i     = reqWe[0];
  assign ifA.req_addr_i   = reqAddr[0];
  assign ifA.req_wdata_i  = reqWdata[0];
  assign ifA.resp_ready_i = respReady[0];
  assign reqReady[0]      = ifA.req_ready_o;
  assign respValid[0]     = ifA.resp_valid_o;
  assign respRdata[0]     = ifA.resp_rdata_o;
  assign respErr[0]       = ifA.resp_err_o;

  assign ifB.req_valid_i  = reqValid[1];
  assign ifB.req_we_i     = reqWe[1];
  assign ifB.req_addr_i   = reqAddr[1];
  assign ifB.req_wdata_i  = reqWdata[1];
  assign ifB.resp_ready_i = respReady[1];
  assign reqReady[1]      = ifB.req_ready_o;
  assign respValid[1]     = ifB.resp_valid_o;
  assign respRdata[1]     = ifB.resp_rdata_o;
  assign respErr[1]       = ifB.resp_err_o;

  dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifA)
  );

  dmem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on responder d; expectations come from the word-array model.
  task automatic runTxn(input int d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    int            idx;
    bit            isErr;
    bit            checkData;
    logic [31:0]   expData;
    logic [31:0]   held;
    int            expLat;
    int            lat;
    int            n;
    expLat    = (d == 0) ? 3 : 1;
    idx       = int'((addr / 4) % DEPTH);
`ifdef DMEM_ERR_EN
    isErr     = (addr % 4 != 0) || (addr >= DEPTH * 4);
`else
    isErr     = 1'b0;
`endif
    checkData = 1'b1;
    expData   = 32'h0;
    if (!isErr && !we) begin
      if (known[d][idx]) expData = modelMem[d][idx];
      else checkData = 1'b0;
    end
    if (!isErr && we) begin
      modelMem[d][idx] = wdata;
      known[d][idx]    = 1'b1;
    end

    @(negedge clk);
    reqValid[d] = 1'b1;
    reqWe[d]    = we;
    reqAddr[d]  = addr;
    reqWdata[d] = wdata;
    n = 0;
    while (!reqReady[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("acceptReady", 32'(reqReady[d]), 32'd1);
    @(posedge clk);
    acceptTime[d] = $time;
    #1;
    reqValid[d] = 1'b0;
    reqWdata[d] = $urandom;
    check("validAfterAccept", 32'(respValid[d]), 32'd0);

    lat = 0;
    while (!respValid[d] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(expLat));
    check("readyBusy", 32'(reqReady[d]), 32'd0);
    if (checkData) check("rdata", respRdata[d], expData);
    check("err", 32'(respErr[d]), 32'(isErr));

    held = respRdata[d];
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("holdValid", 32'(respValid[d]), 32'd1);
      check("holdData", respRdata[d], held);
      check("holdReady", 32'(reqReady[d]), 32'd0);
    end
    respReady[d] = 1'b1;
    @(posedge clk);
    #1;
    respReady[d] = 1'b0;
    check("postHsReady", 32'(reqReady[d]), 32'd1);
    check("postHsValid", 32'(respValid[d]), 32'd0);
  endtask

  initial begin
    time t0;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      reqValid[d]  = 1'b0;
      reqWe[d]     = 1'b0;
      reqAddr[d]   = '0;
      reqWdata[d]  = '0;
      respReady[d] = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) known[d][i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < 2; d++) begin
      check("rstReady", 32'(reqReady[d]), 32'd1);
      check("rstValid", 32'(respValid[d]), 32'd0);
      check("rstRdata", respRdata[d], 32'd0);
      check("rstErr", 32'(respErr[d]), 32'd0);
    end

    // Store then load at 0x10 with a long back-pressure window on the response.
    runTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
    runTxn(0, 1'b0, 32'h10, 32'h0, 5);

    // Zero-wait responder: consecutive loads, one cycle latency, at least two cycles apart.
    runTxn(1, 1'b1, 32'h8, 32'hCAFE0001, 0);
    runTxn(1, 1'b0, 32'h8, 32'h0, 0);
    t0 = acceptTime[1];
    runTxn(1, 1'b0, 32'h8, 32'h0, 0);
    check("acceptSpacing", 32'((acceptTime[1] - t0) >= 20), 32'd1);

    // Reset during WAIT discards the pending store.
    runTxn(0, 1'b1, 32'h20, 32'h0BADF00D, 0);
    @(negedge clk);
    reqValid[0] = 1'b1;
    reqWe[0]    = 1'b1;
    reqAddr[0]  = 32'h20;
    reqWdata[0] = 32'h12345678;
    @(posedge clk);
    #1;
    reqValid[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midRstValid", 32'(respValid[0]), 32'd0);
    check("midRstReady", 32'(reqReady[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    runTxn(0, 1'b0, 32'h20, 32'h0, 0);

    // Out-of-range, misaligned and wrapping addresses.
    runTxn(0, 1'b1, 32'h0, 32'h11112222, 0);
    runTxn(0, 1'b0, DEPTH * 4, 32'h0, 0);
    runTxn(0, 1'b1, 32'h22, 32'h33334444, 1);
    runTxn(0, 1'b0, 32'h20, 32'h0, 0);
    runTxn(0, 1'b1, 32'h4, 32'h01020304, 0);
    runTxn(0, 1'b1, DEPTH * 4 + 4, 32'hA5A5A5A5, 0);
    runTxn(0, 1'b0, 32'h4, 32'h0, 0);

    // Random traffic over a small window of words so loads mostly hit stored data.
    for (int k = 0; k < 45; k++) begin
      int d;
      d = (k % 3 == 2) ? 1 : 0;
      a = 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 3) == 0) a = a + 32'(DEPTH * 4);
      if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
      runTxn(d, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
